rr_grant_scheduler: RTL and testbench



---
 rtl/rr_grant_scheduler.sv | 168 ++++++++++++++++
 tb/tb_rr_grant_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_scheduler.sv
// -----------------------------------------------------------------------------
// rr_grant_scheduler
//
// Round-robin arbiter that shares one downstream resource among N requesters.
// A registered one-hot grant selects the current owner. The grant is held
// until the owner signals completion, drops its request, or uses up its hold
// budget while someone else is waiting. Handoffs are back-to-back: a release
// with another eligible requester goes straight to the new owner, with no idle
// cycle in between.
//
// State table:
//   state | meaning
//   IDLE  | no owner; O is all-zero, waiting for any request
//   GRANT | one requester owns the resource; O is one-hot
//
// Ports:
//   CLK         in   1          rising-edge clock
//   ASYNCRESET  in   1          asynchronous, active-high reset
//   req         in   N          per-requester request level (bit i = requester i)
//   done        in   1          one-cycle pulse: the current owner's transaction is complete
//   O           out  N          registered one-hot grant, all-zero when idle
//   busy        out  1          OR-reduction of O
//   grant_id    out  ID_W       binary index of the set bit of O, 0 when idle
//   hold_cnt    out  HW         consecutive cycles the current owner has held the grant
// -----------------------------------------------------------------------------
module rr_grant_scheduler #(
  parameter  int N        = 2,
  parameter  int HOLD_MAX = 4,
  localparam int ID_W     = (N <= 2) ? 1 : $clog2(N),
  localparam int HW       = $clog2(HOLD_MAX + 1)
) (
  input  logic            CLK,
  input  logic            ASYNCRESET,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    O,
  output logic            busy,
  output logic [ID_W-1:0] grant_id,
  output logic [HW-1:0]   hold_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [HW-1:0]   hold_q,  hold_d;
  logic [ID_W-1:0] ptr_q,   ptr_d;

  logic [ID_W-1:0] owner_id;
  logic [ID_W-1:0] ptr_inc;
  logic            owner_req;
  logic            others_req;
  logic            rel_done;
  logic            rel_drop;
  logic            rel_hold;
  logic            release_ev;
  logic            excl_owner;
  logic [N-1:0]    pick_mask;
  logic [ID_W-1:0] pick_start;
  logic [N-1:0]    pick_win;

  // First set bit of mask, searching start, start+1, ... wrapping mod N.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0]    mask,
                                           input logic [ID_W-1:0] start);
    logic [N-1:0]    win;
    logic [ID_W-1:0] idx;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = ID_W'((int'(start) + off) % N);
      if (!found && mask[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

  // Binary index of the owner; grant_q is one-hot or zero.
  always_comb begin
    owner_id = '0;
    for (int j = 0; j < N; j++) begin
      if (grant_q[j]) owner_id = ID_W'(j);
    end
  end

  assign ptr_inc    = (owner_id == ID_W'(N - 1)) ? '0 : owner_id + ID_W'(1);

  assign owner_req  = |(req & grant_q);
  assign others_req = |(req & ~grant_q);

  assign rel_done   = done;
  assign rel_drop   = ~owner_req;
  assign rel_hold   = (hold_q == HW'(HOLD_MAX)) && others_req;
  assign release_ev = rel_done | rel_drop | rel_hold;

  // A drop or a budget preemption takes the owner out of the running. A plain
  // completion keeps it eligible; starting the search at owner+1 makes it
  // the last candidate.
  assign excl_owner = rel_drop | rel_hold;

  assign pick_start = (state_q == IDLE) ? ptr_q : ptr_inc;
  assign pick_mask  = (state_q == GRANT && excl_owner) ? (req & ~grant_q) : req;
  assign pick_win   = rr_pick(pick_mask, pick_start);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick_win;
          hold_d  = HW'(1);
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (release_ev) begin
          ptr_d = ptr_inc;
          if (|pick_win) begin
            grant_d = pick_win;
            hold_d  = HW'(1);
          end else begin
            grant_d = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (hold_q != HW'(HOLD_MAX)) begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: begin
        grant_d = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign O        = grant_q;
  assign busy     = |grant_q;
  assign grant_id = owner_id;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
module tb_rr_grant_scheduler;

  logic       CLK;
  logic       ASYNCRESET;
  logic [1:0] req;
  logic       done;
  logic [1:0] O;
  logic       busy;
  logic [0:0] grant_id;
  logic [2:0] hold_cnt;

  int vectors;
  int miscompares;

  // {O, busy, grant_id, hold_cnt}
  logic [6:0] obs;
  assign obs = {O, busy, grant_id, hold_cnt};

  rr_grant_scheduler #(.N(2), .HOLD_MAX(4)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .req        (req),
    .done       (done),
    .O          (O),
    .busy       (busy),
    .grant_id   (grant_id),
    .hold_cnt   (hold_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    req        = 2'b00;
    done       = 1'b0;
    ASYNCRESET = 1'b1;
    #3;
    ASYNCRESET = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    ASYNCRESET = 1'b1;
    req        = 2'b11;
    done       = 1'b0;
    #2;
    exp = {2'b00, 1'b0, 1'b0, 3'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_async obs=%b expected=%b", obs, exp);
    end
    step();
    step();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_ignores_req obs=%b expected=%b", obs, exp);
    end
    req        = 2'b00;
    ASYNCRESET = 1'b0;
    step();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_idle obs=%b expected=%b", obs, exp);
    end
  endtask

  task automatic test_done_idle();
    logic [6:0] exp;
    do_reset();
    done = 1'b1;
    step();
    done = 1'b0;
    exp  = {2'b00, 1'b0, 1'b0, 3'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL done_in_idle obs=%b expected=%b", obs, exp);
    end
  endtask

  task automatic test_single_hold();
    logic [6:0] exp;
    logic [2:0] hold_tab [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    do_reset();
    req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      exp = {2'b01, 1'b1, 1'b0, hold_tab[i]};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_hold[%0d] obs=%b expected=%b", i, obs, exp);
      end
    end
  endtask

  // Continues from test_single_hold: owner 0 holds with hold_cnt saturated.
  task automatic test_drop_and_wrap();
    logic [6:0] exp;
    req = 2'b00;
    step();
    exp = {2'b00, 1'b0, 1'b0, 3'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL drop_to_idle obs=%b expected=%b", obs, exp);
    end
    req = 2'b01;
    step();
    exp = {2'b01, 1'b1, 1'b0, 3'd1};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL ptr_wrap_regrant obs=%b expected=%b", obs, exp);
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_done_handoff();
    logic [6:0] exp;
    do_reset();
    req = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = {2'b01, 1'b1, 1'b0, 3'(i)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL done_pre[%0d] obs=%b expected=%b", i, obs, exp);
      end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    exp  = {2'b10, 1'b1, 1'b1, 3'd1};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL done_handoff obs=%b expected=%b", obs, exp);
    end
  endtask

  // A completion with no one else waiting re-grants the same owner.
  task automatic test_done_lone();
    logic [6:0] exp;
    do_reset();
    req = 2'b01;
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    exp  = {2'b01, 1'b1, 1'b0, 3'd1};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL done_lone_regrant obs=%b expected=%b", obs, exp);
    end
  endtask

  task automatic test_alternation();
    logic [6:0] exp;
    logic [1:0] exp_o;
    do_reset();
    req = 2'b11;
    for (int n = 1; n <= 16; n++) begin
      step();
      exp_o = (((n - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      exp   = {exp_o, 1'b1, exp_o[1], 3'(((n - 1) % 4) + 1)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL alternation[%0d] obs=%b expected=%b", n, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp;
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 4; i++) step();
    exp = {2'b01, 1'b1, 1'b0, 3'd4};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL b2b_saturated obs=%b expected=%b", obs, exp);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    exp  = {2'b10, 1'b1, 1'b1, 3'd1};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL b2b_single_handoff obs=%b expected=%b", obs, exp);
    end
    for (int i = 2; i <= 4; i++) begin
      step();
      exp = {2'b10, 1'b1, 1'b1, 3'(i)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL b2b_hold1[%0d] obs=%b expected=%b", i, obs, exp);
      end
    end
    step();
    exp = {2'b01, 1'b1, 1'b0, 3'd1};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL b2b_return_owner0 obs=%b expected=%b", obs, exp);
    end
  endtask

  task automatic test_async_midgrant();
    logic [6:0] exp;
    do_reset();
    req = 2'b10;
    step();
    exp = {2'b10, 1'b1, 1'b1, 3'd1};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL async_pre_grant obs=%b expected=%b", obs, exp);
    end
    #2;
    ASYNCRESET = 1'b1;
    #1;
    exp = {2'b00, 1'b0, 1'b0, 3'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL async_immediate obs=%b expected=%b", obs, exp);
    end
    step();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL async_held obs=%b expected=%b", obs, exp);
    end
    ASYNCRESET = 1'b0;
    step();
    exp = {2'b10, 1'b1, 1'b1, 3'd1};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL async_regrant obs=%b expected=%b", obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ASYNCRESET  = 1'b1;
    req         = 2'b00;
    done        = 1'b0;
    test_reset();
    test_done_idle();
    test_single_hold();
    test_drop_and_wrap();
    test_done_handoff();
    test_done_lone();
    test_alternation();
    test_back_to_back();
    test_async_midgrant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
